mux_sel_ctrl: RTL

- Generates the 1-bit select for the downstream two-input source mux (sel -> mux sel: 1 selects in_1, 0 selects in_2).
- Takes a raw push-button and a frame-sync pulse, debounces the button, and toggles sel only on a frame boundary. This prevents a mid-frame source change.
- Also accepts a software force request.
- After each switch, a frame-count hold-off blocks button requests.

---
 rtl/mux_sel_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mux_sel_ctrl.sv
// Frame-aligned source select for a two-input video mux.
// Debounced button / force request arms a toggle applied on vsync.
module mux_sel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLDOFF_FRAMES  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  input  logic vsync_in,
  input  logic force_valid,
  input  logic force_sel,
  output logic sel,
  output logic switch_pending,
  output logic switch_done
);

  localparam int CW = (DEBOUNCE_CYCLES < 3) ? 1
                    : $clog2(DEBOUNCE_CYCLES);
  localparam int HW = (HOLDOFF_FRAMES < 2) ? 1
                    : $clog2(HOLDOFF_FRAMES + 1);

  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF_FRAMES);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_VS = 2'd1;
  localparam logic [1:0] HOLDOFF = 2'd2;

  logic          key_s1;
  logic          key_s2;
  logic          vs_s1;
  logic          vs_s2;
  logic          vs_prev;
  logic          vs_edge;
  logic          key_db;
  logic          key_db_prev;
  logic [CW-1:0] db_cnt;
  logic          press;

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_nx;
  logic          sel_nx;
  logic          done_nx;
  logic          force_chg;
  logic          force_same;

  // Bring the asynchronous button and frame sync into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      key_s1  <= 1'b1;
      key_s2  <= 1'b1;
      vs_s1   <= 1'b0;
      vs_s2   <= 1'b0;
      vs_prev <= 1'b0;
      vs_edge <= 1'b0;
    end else begin
      key_s1  <= key_in;
      key_s2  <= key_s1;
      vs_s1   <= vsync_in;
      vs_s2   <= vs_s1;
      vs_prev <= vs_s2;
      vs_edge <= vs_s2 & ~vs_prev;
    end
  end

  // Accept a new key level only after it has been stable long enough
  always_ff @(posedge clk) begin
    if (rst) begin
      key_db      <= 1'b1;
      key_db_prev <= 1'b1;
      db_cnt      <= '0;
    end else begin
      key_db_prev <= key_db;
      if (key_s2 == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_MAX) begin
        key_db <= key_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press      = key_db_prev & ~key_db;
  assign force_chg  = force_valid & (force_sel != sel);
  assign force_same = force_valid & (force_sel == sel);

  // Arm / switch / hold-off decisions; sel only moves on vs_edge
  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    sel_nx   = sel;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (force_chg || press) begin
          state_nx = WAIT_VS;
        end
      end
      WAIT_VS: begin
        if (force_same) begin
          state_nx = IDLE;
        end else if (vs_edge) begin
          sel_nx  = ~sel;
          done_nx = 1'b1;
          if (HOLDOFF_FRAMES == 0) begin
            state_nx = IDLE;
          end else begin
            state_nx = HOLDOFF;
            hold_nx  = HOLD_INIT;
          end
        end
      end
      HOLDOFF: begin
        if (force_chg) begin
          state_nx = WAIT_VS;
          hold_nx  = '0;
        end else if (vs_edge) begin
          if (hold_cnt <= HW'(1)) begin
            state_nx = IDLE;
            hold_nx  = '0;
          end else begin
            hold_nx = hold_cnt - 1'b1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        hold_nx  = '0;
      end
    endcase
  end

  // Register FSM state and all outputs together
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      hold_cnt       <= '0;
      sel            <= 1'b0;
      switch_done    <= 1'b0;
      switch_pending <= 1'b0;
    end else begin
      state          <= state_nx;
      hold_cnt       <= hold_nx;
      sel            <= sel_nx;
      switch_done    <= done_nx;
      switch_pending <= (state_nx == WAIT_VS);
    end
  end

endmodule
